vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator, successor to the fixed 640x480 timing block. It produces the pixel coordinates, sync pulses, active-video flag and frame/line strobes for the display pipeline (framebuffer read, sprite/trail renderer). New relative to the fixed generator:
- Any video mode via parameters.
- Selectable sync polarity.
- Pixel clock-enable, so one system clock can drive a slower pixel rate.
- Zero-skew registered outputs: all outputs describe the same pixel.
- Frame/line/vblank strobes for renderer scheduling.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_axis_counter.sv | 80 ++++++++
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 tb/tb_vga_timing_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA raster timing generator.
//   - VGA640_* : 640x480@60 mode (default parameter set of vga_timing_gen)
//   - VGA800_* : 800x600@72 mode, positive sync polarity
//   - vga_total(): line/frame length from active + porches + sync
// -----------------------------------------------------------------------------
package vga_pkg;

   // 640x480@60
   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FP     = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BP     = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FP     = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BP     = 33;
   localparam int VGA640_HS_POL   = 0;
   localparam int VGA640_VS_POL   = 0;

   // 800x600@72
   localparam int VGA800_H_ACTIVE = 800;
   localparam int VGA800_H_FP     = 56;
   localparam int VGA800_H_SYNC   = 120;
   localparam int VGA800_H_BP     = 64;
   localparam int VGA800_V_ACTIVE = 600;
   localparam int VGA800_V_FP     = 37;
   localparam int VGA800_V_SYNC   = 6;
   localparam int VGA800_V_BP     = 23;
   localparam int VGA800_HS_POL   = 1;
   localparam int VGA800_VS_POL   = 1;

   function automatic int vga_total(input int active, input int fp,
                                    input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: position counter with wrap, plus decode of the value the
// counter loads on this edge (sync window, active window).
// Ports:
//   i_clk          system clock
//   i_rst          synchronous active-high reset (count -> 0)
//   i_en           advance enable for this axis
//   o_count        current position (registered)
//   o_next         value loaded on the coming edge (o_count when i_en=0)
//   o_wrap         i_en and count at TOTAL-1 (counter returns to 0 this edge)
//   o_sync_next    o_next lies inside the sync window
//   o_active_next  o_next lies inside the active window
// -----------------------------------------------------------------------------
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   parameter int CW     = 11
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_en,
   output logic [CW-1:0] o_count,
   output logic [CW-1:0] o_next,
   output logic          o_wrap,
   output logic          o_sync_next,
   output logic          o_active_next
);

   localparam int TOTAL = vga_total(ACTIVE, FP, SYNC, BP);
   localparam int CWX   = CW + 1;

   // Window bounds carry one extra bit so a window ending exactly at 2^CW
   // (zero back porch with a full-width counter) does not truncate to 0.
   localparam logic [CW-1:0]  C_LAST      = CW'(TOTAL - 1);
   localparam logic [CWX-1:0] C_ACTIVE    = CWX'(ACTIVE);
   localparam logic [CWX-1:0] C_SYNC_BEG  = CWX'(ACTIVE + FP);
   localparam logic [CWX-1:0] C_SYNC_END  = CWX'(ACTIVE + FP + SYNC);

   if (ACTIVE < 1) begin : g_bad_active
      $error("vga_axis_counter: ACTIVE must be at least 1");
   end
   if (TOTAL > (1 << CW)) begin : g_bad_width
      $error("vga_axis_counter: CW too narrow for axis total");
   end

   logic [CW-1:0]  r_count;
   logic [CW-1:0]  w_next;
   logic [CWX-1:0] w_next_x;
   logic           w_term;

   assign w_term = (r_count == C_LAST);

   always_comb begin
      w_next = r_count;
      if (i_en) begin
         w_next = w_term ? '0 : r_count + CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= w_next;
      end
   end

   assign w_next_x      = {1'b0, w_next};
   assign o_count       = r_count;
   assign o_next        = w_next;
   assign o_wrap        = i_en & w_term;
   assign o_sync_next   = (w_next_x >= C_SYNC_BEG) && (w_next_x < C_SYNC_END);
   assign o_active_next = (w_next_x < C_ACTIVE);

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. Every output is registered on the
// same edge and describes the same pixel (PX, PY).
// Ports:
//   CLOCK         system clock
//   RESET         synchronous active-high reset, dominant over PIX_CE
//   PIX_CE        pixel clock-enable; raster advances only when high
//   PX, PY        current pixel coordinates
//   VGA_HS/VGA_VS sync outputs, polarity per HS_POL/VS_POL
//   IS_DRAWING    PX/PY inside the visible area
//   LINE_START    one-CLOCK pulse on the edge where PX becomes 0
//   FRAME_START   one-CLOCK pulse on the edge where (PX,PY) becomes (0,0)
//   VBLANK_START  one-CLOCK pulse on the edge where (PX,PY) becomes (0,V_ACTIVE)
// -----------------------------------------------------------------------------
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA640_H_ACTIVE,
   parameter int H_FP     = VGA640_H_FP,
   parameter int H_SYNC   = VGA640_H_SYNC,
   parameter int H_BP     = VGA640_H_BP,
   parameter int V_ACTIVE = VGA640_V_ACTIVE,
   parameter int V_FP     = VGA640_V_FP,
   parameter int V_SYNC   = VGA640_V_SYNC,
   parameter int V_BP     = VGA640_V_BP,
   parameter int HS_POL   = VGA640_HS_POL,
   parameter int VS_POL   = VGA640_VS_POL,
   parameter int CW       = 11
) (
   input  logic          CLOCK,
   input  logic          RESET,
   input  logic          PIX_CE,
   output logic [CW-1:0] PX,
   output logic [CW-1:0] PY,
   output logic          VGA_HS,
   output logic          VGA_VS,
   output logic          IS_DRAWING,
   output logic          LINE_START,
   output logic          FRAME_START,
   output logic          VBLANK_START
);

   localparam logic          C_HS_POL   = 1'(HS_POL);
   localparam logic          C_VS_POL   = 1'(VS_POL);
   localparam logic [CW-1:0] C_V_ACTIVE = CW'(V_ACTIVE);

   logic [CW-1:0] w_h_count, w_h_next, w_v_count, w_v_next;
   logic          w_h_wrap, w_v_wrap, w_v_en;
   logic          w_hs_next, w_vs_next, w_h_act_next, w_v_act_next;

   logic r_hs, r_vs, r_draw, r_line, r_frame, r_vblank;

   assign w_v_en = PIX_CE & w_h_wrap;

   vga_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .CW     (CW)
   ) u_h_axis (
      .i_clk         (CLOCK),
      .i_rst         (RESET),
      .i_en          (PIX_CE),
      .o_count       (w_h_count),
      .o_next        (w_h_next),
      .o_wrap        (w_h_wrap),
      .o_sync_next   (w_hs_next),
      .o_active_next (w_h_act_next)
   );

   vga_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .CW     (CW)
   ) u_v_axis (
      .i_clk         (CLOCK),
      .i_rst         (RESET),
      .i_en          (w_v_en),
      .o_count       (w_v_count),
      .o_next        (w_v_next),
      .o_wrap        (w_v_wrap),
      .o_sync_next   (w_vs_next),
      .o_active_next (w_v_act_next)
   );

   // Levels are loaded from the counters' next values so they land on the same
   // edge as the coordinates. Strobes are re-evaluated every CLOCK, so a sparse
   // PIX_CE can never stretch them.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         r_hs     <= ~C_HS_POL;
         r_vs     <= ~C_VS_POL;
         r_draw   <= 1'b1;
         r_line   <= 1'b0;
         r_frame  <= 1'b0;
         r_vblank <= 1'b0;
      end else begin
         r_line   <= PIX_CE & (w_h_next == '0);
         r_frame  <= w_h_wrap & w_v_wrap;
         r_vblank <= w_h_wrap & (w_v_next == C_V_ACTIVE);
         if (PIX_CE) begin
            r_hs   <= w_hs_next ~^ C_HS_POL;
            r_vs   <= w_vs_next ~^ C_VS_POL;
            r_draw <= w_h_act_next & w_v_act_next;
         end
      end
   end

   assign PX           = w_h_count;
   assign PY           = w_v_count;
   assign VGA_HS       = r_hs;
   assign VGA_VS       = r_vs;
   assign IS_DRAWING   = r_draw;
   assign LINE_START   = r_line;
   assign FRAME_START  = r_frame;
   assign VBLANK_START = r_vblank;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
   import vga_pkg::*;

   typedef struct {
      int ha, hf, hs, hb, va, vf, vs, vb, hp, vp;
   } mode_t;

   typedef struct {
      int px, py;
      bit hs, vs, draw, ls, fs, vb;
   } out_t;

   typedef struct {
      int   dut;
      out_t o;
   } sb_t;

   // ce_mode: 0 = hold, 1 = always on, 2 = toggling starting with 1
   typedef struct {
      bit rst;
      int ce_mode;
      int n;
      int dpx, dpy, ppx, ppy, spx, spy;
   } phase_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ce  = 1'b0;

   always #5 clk = ~clk;

   // index 0: default 640x480, index 1: 800x600 preset, index 2: small mode
   logic [10:0] d_px, d_py, p_px, p_py;
   logic [3:0]  s_px, s_py;
   logic d_hs, d_vs, d_draw, d_ls, d_fs, d_vb;
   logic p_hs, p_vs, p_draw, p_ls, p_fs, p_vb;
   logic s_hs, s_vs, s_draw, s_ls, s_fs, s_vb;

   vga_timing_gen u_def (
      .CLOCK(clk), .RESET(rst), .PIX_CE(ce), .PX(d_px), .PY(d_py),
      .VGA_HS(d_hs), .VGA_VS(d_vs), .IS_DRAWING(d_draw),
      .LINE_START(d_ls), .FRAME_START(d_fs), .VBLANK_START(d_vb)
   );

   vga_timing_gen #(
      .H_ACTIVE(VGA800_H_ACTIVE), .H_FP(VGA800_H_FP), .H_SYNC(VGA800_H_SYNC),
      .H_BP(VGA800_H_BP), .V_ACTIVE(VGA800_V_ACTIVE), .V_FP(VGA800_V_FP),
      .V_SYNC(VGA800_V_SYNC), .V_BP(VGA800_V_BP),
      .HS_POL(VGA800_HS_POL), .VS_POL(VGA800_VS_POL), .CW(11)
   ) u_pre (
      .CLOCK(clk), .RESET(rst), .PIX_CE(ce), .PX(p_px), .PY(p_py),
      .VGA_HS(p_hs), .VGA_VS(p_vs), .IS_DRAWING(p_draw),
      .LINE_START(p_ls), .FRAME_START(p_fs), .VBLANK_START(p_vb)
   );

   // Zero back porch, CW sized so the sync window ends exactly at 2^CW-1.
   vga_timing_gen #(
      .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(0),
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
      .HS_POL(0), .VS_POL(1), .CW(4)
   ) u_sml (
      .CLOCK(clk), .RESET(rst), .PIX_CE(ce), .PX(s_px), .PY(s_py),
      .VGA_HS(s_hs), .VGA_VS(s_vs), .IS_DRAWING(s_draw),
      .LINE_START(s_ls), .FRAME_START(s_fs), .VBLANK_START(s_vb)
   );

   mode_t md[3];
   string nm[3];
   int    mh[3];
   int    mv[3];
   sb_t   sb_q[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc    = 0;

   function automatic out_t model_step(input int d, input bit r, input bit c);
      out_t o;
      int   ht, vt;
      bit   hw, vw, hs_on, vs_on;
      ht = md[d].ha + md[d].hf + md[d].hs + md[d].hb;
      vt = md[d].va + md[d].vf + md[d].vs + md[d].vb;
      o.ls = 1'b0; o.fs = 1'b0; o.vb = 1'b0;
      if (r) begin
         mh[d] = 0;
         mv[d] = 0;
      end else if (c) begin
         hw = (mh[d] == ht - 1);
         mh[d] = hw ? 0 : mh[d] + 1;
         if (hw) begin
            vw = (mv[d] == vt - 1);
            mv[d] = vw ? 0 : mv[d] + 1;
            o.ls = 1'b1;
            o.fs = vw;
            o.vb = (mv[d] == md[d].va);
         end
      end
      o.px = mh[d];
      o.py = mv[d];
      hs_on = (mh[d] >= md[d].ha + md[d].hf) && (mh[d] < md[d].ha + md[d].hf + md[d].hs);
      vs_on = (mv[d] >= md[d].va + md[d].vf) && (mv[d] < md[d].va + md[d].vf + md[d].vs);
      o.hs   = (hs_on == (md[d].hp != 0));
      o.vs   = (vs_on == (md[d].vp != 0));
      o.draw = (mh[d] < md[d].ha) && (mv[d] < md[d].va);
      return o;
   endfunction

   function automatic out_t dut_out(input int d);
      out_t o;
      case (d)
         0: begin
            o.px = int'(d_px); o.py = int'(d_py); o.hs = d_hs; o.vs = d_vs;
            o.draw = d_draw; o.ls = d_ls; o.fs = d_fs; o.vb = d_vb;
         end
         1: begin
            o.px = int'(p_px); o.py = int'(p_py); o.hs = p_hs; o.vs = p_vs;
            o.draw = p_draw; o.ls = p_ls; o.fs = p_fs; o.vb = p_vb;
         end
         default: begin
            o.px = int'(s_px); o.py = int'(s_py); o.hs = s_hs; o.vs = s_vs;
            o.draw = s_draw; o.ls = s_ls; o.fs = s_fs; o.vb = s_vb;
         end
      endcase
      return o;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
      end
   endtask

   task automatic cmp_out(input int d, input out_t e);
      out_t a;
      a = dut_out(d);
      chk({nm[d], ".PX"},           a.px,        e.px);
      chk({nm[d], ".PY"},           a.py,        e.py);
      chk({nm[d], ".VGA_HS"},       int'(a.hs),   int'(e.hs));
      chk({nm[d], ".VGA_VS"},       int'(a.vs),   int'(e.vs));
      chk({nm[d], ".IS_DRAWING"},   int'(a.draw), int'(e.draw));
      chk({nm[d], ".LINE_START"},   int'(a.ls),   int'(e.ls));
      chk({nm[d], ".FRAME_START"},  int'(a.fs),   int'(e.fs));
      chk({nm[d], ".VBLANK_START"}, int'(a.vb),   int'(e.vb));
   endtask

   // Drive on the falling edge, predict, then compare 1 time unit after the
   // rising edge.
   task automatic tick(input bit r, input bit c);
      sb_t e;
      rst = r;
      ce  = c;
      for (int d = 0; d < 3; d++) begin
         e.dut = d;
         e.o   = model_step(d, r, c);
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      cyc++;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         cmp_out(e.dut, e.o);
      end
      @(negedge clk);
   endtask

   phase_t ph[6];

   initial begin
      int fs_cnt, fs_first, vb_cnt, vb_first;
      int p_hs_cnt, d_hs_cnt, d_draw_cnt, p_draw_cnt;
      bit c;

      md[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
      md[1] = '{800, 56, 120, 64, 600, 37, 6, 23, 1, 1};
      md[2] = '{10, 2, 3, 0, 6, 1, 2, 2, 0, 1};
      nm[0] = "def"; nm[1] = "pre"; nm[2] = "sml";
      for (int d = 0; d < 3; d++) begin
         mh[d] = 0;
         mv[d] = 0;
      end

      //         rst ce  n     def(px,py) pre(px,py) sml(px,py)
      ph[0] = '{1, 1, 2,    0,   0, 0,   0, 0, 0};
      ph[1] = '{0, 1, 495,  495, 0, 495, 0, 0, 0};
      ph[2] = '{0, 2, 40,   515, 0, 515, 0, 5, 1};
      ph[3] = '{0, 1, 1000, 715, 1, 475, 1, 0, 2};
      ph[4] = '{0, 0, 5,    715, 1, 475, 1, 0, 2};
      ph[5] = '{0, 1, 2000, 315, 4, 395, 3, 5, 3};

      @(negedge clk);
      for (int p = 0; p < 6; p++) begin
         for (int i = 0; i < ph[p].n; i++) begin
            c = (ph[p].ce_mode == 1) || (ph[p].ce_mode == 2 && (i % 2) == 0);
            tick(ph[p].rst, c);
         end
         chk($sformatf("phase%0d.def.PX", p), int'(d_px), ph[p].dpx);
         chk($sformatf("phase%0d.def.PY", p), int'(d_py), ph[p].dpy);
         chk($sformatf("phase%0d.pre.PX", p), int'(p_px), ph[p].ppx);
         chk($sformatf("phase%0d.pre.PY", p), int'(p_py), ph[p].ppy);
         chk($sformatf("phase%0d.sml.PX", p), int'(s_px), ph[p].spx);
         chk($sformatf("phase%0d.sml.PY", p), int'(s_py), ph[p].spy);
      end

      // Reset mid-frame inside both sync windows of the small mode: (13,8).
      for (int i = 0; i < 83; i++) tick(1'b0, 1'b1);
      chk("midrst.pre.PX", int'(s_px), 13);
      chk("midrst.pre.PY", int'(s_py), 8);
      chk("midrst.pre.HS", int'(s_hs), 0);
      chk("midrst.pre.VS", int'(s_vs), 1);
      tick(1'b1, 1'b1);
      chk("midrst.PX",          int'(s_px),   0);
      chk("midrst.PY",          int'(s_py),   0);
      chk("midrst.HS",          int'(s_hs),   1);
      chk("midrst.VS",          int'(s_vs),   0);
      chk("midrst.IS_DRAWING",  int'(s_draw), 1);
      chk("midrst.FRAME_START", int'(s_fs),   0);
      chk("midrst.def.HS",      int'(d_hs),   1);
      chk("midrst.def.VS",      int'(d_vs),   1);

      // Free run from reset: frame/vblank strobes of the small mode, one full
      // preset line and the start of the next.
      fs_cnt = 0; fs_first = -1; vb_cnt = 0; vb_first = -1;
      p_hs_cnt = 0; d_hs_cnt = 0; d_draw_cnt = 0; p_draw_cnt = 0;
      for (int k = 1; k <= 1040; k++) begin
         tick(1'b0, 1'b1);
         if (s_fs) begin
            fs_cnt++;
            if (fs_first < 0) fs_first = k;
            chk("wrap.sml.LINE_START",   int'(s_ls), 1);
            chk("wrap.sml.VBLANK_START", int'(s_vb), 0);
            chk("wrap.sml.PY",           int'(s_py), 0);
         end
         if (s_vb) begin
            vb_cnt++;
            if (vb_first < 0) vb_first = k;
         end
         if (p_hs)   p_hs_cnt++;
         if (!d_hs)  d_hs_cnt++;
         if (d_draw) d_draw_cnt++;
         if (p_draw) p_draw_cnt++;
         if (k == 1039) chk("pre.PX_last", int'(p_px), 1039);
         if (k == 1040) begin
            chk("pre.PX_wrap",      int'(p_px), 0);
            chk("pre.PY_wrap",      int'(p_py), 1);
            chk("pre.LINE_START",   int'(p_ls), 1);
            chk("pre.FRAME_START",  int'(p_fs), 0);
         end
      end
      chk("sml.frame_count",  fs_cnt,     6);
      chk("sml.first_frame",  fs_first,   165);
      chk("sml.vblank_count", vb_cnt,     6);
      chk("sml.first_vblank", vb_first,   90);
      chk("pre.hs_high_cnt",  p_hs_cnt,   120);
      chk("def.hs_low_cnt",   d_hs_cnt,   96);
      chk("def.draw_cnt",     d_draw_cnt, 880);
      chk("pre.draw_cnt",     p_draw_cnt, 800);

      // Sparse random enable with occasional reset; model checks every edge.
      for (int i = 0; i < 600; i++) begin
         tick($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
